// File: rtl/tape_mem_ctrl_pkg.sv
// rtl/tape_mem_ctrl_pkg.sv - shared op, source, address and state types for the tape memory
package tape_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    MEM_NOP   = 3'd0,
    MEM_READ  = 3'd1,
    MEM_WRITE = 3'd2,
    MEM_INC   = 3'd3,
    MEM_DEC   = 3'd4
  } mem_op_t;

  // Write-data source index into the packed src_data bus
  typedef logic [2:0] mem_src_t;
  localparam mem_src_t SRC_ACC   = 3'd0;
  localparam mem_src_t SRC_ALU   = 3'd1;
  localparam mem_src_t SRC_STACK = 3'd2;
  localparam mem_src_t SRC_HEAD  = 3'd3;
  localparam mem_src_t SRC_CACHE = 3'd4;
  localparam mem_src_t SRC_SAVE  = 3'd5;

  typedef enum logic {
    ADDR_FROM_HEAD  = 1'b0,
    ADDR_FROM_STACK = 1'b1
  } mem_addr_t;

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    IDLE     = 2'd1,
    RMW_WAIT = 2'd2
  } mem_state_t;

  function automatic logic is_rmw_op(input mem_op_t op);
    return (op == MEM_INC) || (op == MEM_DEC);
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - fixed-latency pipe carrying read/RMW tokens to the response stage
module mem_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_rmw,
  input  logic              in_dec,
  input  logic              in_fault,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_rmw,
  output logic              out_dec,
  output logic              out_fault
);

  localparam int PW = DATA_W + ADDR_W + 3;

  logic [RD_LAT-1:0] vld;
  logic [PW-1:0]     pay [RD_LAT];

  // Valid bits are the only reset state; a reset drops every in-flight token
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
    end
  end

  // Payload shifts unconditionally; it is meaningful only where its valid bit is set
  always_ff @(posedge clk) begin
    pay[0] <= {in_data, in_addr, in_rmw, in_dec, in_fault};
    for (int i = 1; i < RD_LAT; i++) pay[i] <= pay[i-1];
  end

  assign out_valid = vld[RD_LAT-1];
  assign {out_data, out_addr, out_rmw, out_dec, out_fault} = pay[RD_LAT-1];

endmodule

// File: rtl/tape_mem_ctrl.sv
// rtl/tape_mem_ctrl.sv - tape array with clear-after-reset, read pipe and atomic inc/dec
module tape_mem_ctrl
  import tape_mem_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int RD_LAT  = 2,
  parameter int NUM_SRC = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  mem_op_t                   req_op,
  input  mem_src_t                  req_src,
  input  mem_addr_t                 req_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [ADDR_W-1:0]         head_addr,
  input  logic [ADDR_W-1:0]         stack_addr,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_fault,
  output logic                      fault
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  mem_state_t        state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] wdata, rd_data, new_val;
  logic              accept, in_range, req_rmw, rmw_done;

  logic              p_valid, p_rmw, p_dec, p_fault;
  logic [DATA_W-1:0] p_data;
  logic [ADDR_W-1:0] p_addr;

  assign sel_addr = (req_addr == ADDR_FROM_STACK) ? stack_addr : head_addr;
  assign in_range = {1'b0, sel_addr} < DEPTH_LIM;
  assign accept   = req_valid && req_ready;
  assign req_rmw  = is_rmw_op(req_op);
  assign rd_data  = in_range ? mem[sel_addr] : '0;
  assign rmw_done = p_valid && p_rmw;
  assign new_val  = p_dec ? (p_data - DATA_W'(1)) : (p_data + DATA_W'(1));

  // Write-data source mux; indices beyond the implemented sources write zero
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(req_src) == i) wdata = src_data[i*DATA_W +: DATA_W];
    end
  end

  mem_rd_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept && ((req_op == MEM_READ) || req_rmw)),
    .in_data   (rd_data),
    .in_addr   (sel_addr),
    .in_rmw    (req_rmw),
    .in_dec    (req_op == MEM_DEC),
    .in_fault  (!in_range),
    .out_valid (p_valid),
    .out_data  (p_data),
    .out_addr  (p_addr),
    .out_rmw   (p_rmw),
    .out_dec   (p_dec),
    .out_fault (p_fault)
  );

  // Response stage: RMW returns the updated value, faulting tokens return zero
  assign rsp_valid = p_valid;
  assign rsp_fault = p_valid && p_fault;
  assign rsp_data  = (p_valid && !p_fault) ? (p_rmw ? new_val : p_data) : '0;

  // State register; reset always restarts the clear sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  // Next state and ready; ready is withheld while clearing or while an RMW is in flight
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      CLEAR:    if (clr_ptr == LAST_CELL) state_nxt = IDLE;
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && req_rmw) state_nxt = RMW_WAIT;
      end
      RMW_WAIT: if (rmw_done) state_nxt = IDLE;
      default:  state_nxt = CLEAR;
    endcase
  end

  // Clear pointer walks 0..DEPTH-1 once after every reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               clr_ptr <= '0;
    else if (state == CLEAR) clr_ptr <= clr_ptr + ADDR_W'(1);
  end

  // Array write port: clear sweep, then accepted writes, then RMW commits (never the same cycle)
  always_ff @(posedge clk) begin
    if (state == CLEAR)                                  mem[clr_ptr]  <= '0;
    else if (accept && (req_op == MEM_WRITE) && in_range) mem[sel_addr] <= wdata;
    else if (rmw_done && !p_fault)                        mem[p_addr]   <= new_val;
  end

  // Sticky fault flag for any out-of-range access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault <= 1'b0;
    else if (accept && (req_op != MEM_NOP) && !in_range) fault <= 1'b1;
  end

endmodule

// File: tb/tb_tape_mem_ctrl.sv
// tb/tb_tape_mem_ctrl.sv - self-checking bench for tape_mem_ctrl with a random scoreboard run
module tb_tape_mem_ctrl;
  import tape_mem_ctrl_pkg::*;

  localparam int DATA_W = 8, ADDR_W = 8, DEPTH = 200, RD_LAT = 2, NUM_SRC = 6;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      req_valid, req_ready;
  mem_op_t                   req_op;
  mem_src_t                  req_src;
  mem_addr_t                 req_addr;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [ADDR_W-1:0]         head_addr, stack_addr;
  logic                      rsp_valid, rsp_fault, fault;
  logic [DATA_W-1:0]         rsp_data;

  tape_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .NUM_SRC(NUM_SRC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src(req_src), .req_addr(req_addr), .src_data(src_data), .head_addr(head_addr),
    .stack_addr(stack_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic [7:0] data; logic flt;} exp_t;

  int         cyc, busy_until, n_cmp, n_err;
  logic [7:0] model [256];
  logic       model_fault;
  exp_t       q[$];
  logic [7:0] gd [8];
  int         gc [8];

  // Advance one clock, then drop the request and scramble the don't-care inputs
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    req_valid  = 1'b0;
    req_op     = mem_op_t'(3'($urandom_range(0, 4)));
    req_src    = 3'($urandom);
    head_addr  = 8'($urandom);
    stack_addr = 8'($urandom);
    src_data   = {16'($urandom), 32'($urandom)};
  endtask

  // Drive one request and apply its effect to the reference model if it will be accepted
  task automatic issue(input mem_op_t op, input int src, input bit use_stack,
                       input logic [7:0] addr, input logic [7:0] val);
    exp_t       e;
    logic [7:0] nv;
    bit         ok;
    req_valid  = 1'b1;
    req_op     = op;
    req_src    = 3'(src);
    req_addr   = use_stack ? ADDR_FROM_STACK : ADDR_FROM_HEAD;
    head_addr  = use_stack ? 8'($urandom) : addr;
    stack_addr = use_stack ? addr : 8'($urandom);
    src_data   = {16'($urandom), 32'($urandom)};
    if (src < NUM_SRC) src_data[src*DATA_W +: DATA_W] = val;
    ok = int'(addr) < DEPTH;
    if (cyc >= busy_until) begin
      if (op != MEM_NOP && !ok) model_fault = 1'b1;
      e.due = cyc + RD_LAT;
      e.flt = !ok;
      case (op)
        MEM_WRITE: if (ok) model[addr] = (src < NUM_SRC) ? val : 8'h00;
        MEM_READ: begin
          e.data = ok ? model[addr] : 8'h00;
          q.push_back(e);
        end
        MEM_INC, MEM_DEC: begin
          nv = (op == MEM_INC) ? model[addr] + 8'd1 : model[addr] - 8'd1;
          if (ok) model[addr] = nv;
          e.data = ok ? nv : 8'h00;
          q.push_back(e);
          busy_until = cyc + 1 + RD_LAT;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = MEM_NOP; req_src = SRC_ACC; req_addr = ADDR_FROM_HEAD;
    src_data = '0; head_addr = '0; stack_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b exp 0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL rst_rsp_data got %h exp 00", rsp_data); end
    n_cmp++; if (rsp_fault !== 1'b0) begin n_err++; $display("FAIL rst_rsp_fault got %b exp 0", rsp_fault); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault got %b exp 0", fault); end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    model_fault = 1'b0; q.delete(); cyc = 0; busy_until = DEPTH;
    req_valid = 1'b1; req_op = MEM_NOP;
    reset = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 400) begin
      n++; tick(); req_valid = 1'b1; req_op = MEM_NOP;
    end
    n_cmp++; if (n != DEPTH) begin n_err++; $display("FAIL clear_ready_low got %0d cycles exp %0d", n, DEPTH); end
    issue(MEM_READ, 0, 1'b0, 8'h10, 8'h00);
    tick();
    for (int k = 1; k < RD_LAT; k++) begin
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL clear_rsp_early got %b exp 0", rsp_valid); end
      tick();
    end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL clear_rsp_valid got %b exp 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL clear_rsp_data got %h exp 00", rsp_data); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL clear_rsp_single got %b exp 0", rsp_valid); end
  endtask

  task automatic test_write_read();
    issue(MEM_WRITE, int'(SRC_ACC), 1'b0, 8'h05, 8'hA0); tick();
    issue(MEM_READ, 0, 1'b0, 8'h05, 8'h00); repeat (RD_LAT) tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA0) begin n_err++; $display("FAIL wr_acc got v=%b d=%h exp v=1 d=a0", rsp_valid, rsp_data); end
    issue(MEM_WRITE, int'(SRC_ALU), 1'b1, 8'h05, 8'hA1); tick();
    issue(MEM_READ, 0, 1'b1, 8'h05, 8'h00); repeat (RD_LAT) tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA1) begin n_err++; $display("FAIL wr_alu got v=%b d=%h exp v=1 d=a1", rsp_valid, rsp_data); end
    issue(MEM_WRITE, int'(SRC_STACK), 1'b0, 8'h06, 8'h3C); tick();
    issue(MEM_WRITE, 7, 1'b0, 8'h06, 8'hEE); tick();
    issue(MEM_READ, 0, 1'b0, 8'h06, 8'h00); repeat (RD_LAT) tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h00) begin n_err++; $display("FAIL wr_bad_src got v=%b d=%h exp v=1 d=00", rsp_valid, rsp_data); end
  endtask

  task automatic test_streaming();
    int n, a;
    for (int i = 1; i <= 4; i++) begin issue(MEM_WRITE, int'(SRC_HEAD), 1'b0, 8'(i), 8'(17 * i)); tick(); end
    n = 0; a = -1;
    for (int i = 0; i < 4 + RD_LAT + 2; i++) begin
      if (i < 4) issue(MEM_READ, 0, 1'b0, 8'(i + 1), 8'h00);
      tick();
      if (i == 0) a = cyc;
      if (rsp_valid === 1'b1 && n < 8) begin gd[n] = rsp_data; gc[n] = cyc; n++; end
    end
    n_cmp++; if (n != 4) begin n_err++; $display("FAIL stream_count got %0d exp 4", n); end
    for (int k = 0; k < 4 && k < n; k++) begin
      n_cmp++; if (gd[k] !== 8'(17 * (k + 1)) || gc[k] != a + RD_LAT - 1 + k)
        begin n_err++; $display("FAIL stream_%0d got d=%h c=%0d exp d=%h c=%0d", k, gd[k], gc[k], 8'(17 * (k + 1)), a + RD_LAT - 1 + k); end
    end
  endtask

  task automatic test_back_to_back();
    int n, a;
    issue(MEM_WRITE, int'(SRC_CACHE), 1'b0, 8'h09, 8'h99); tick();
    n = 0; a = -1;
    for (int i = 0; i < 3 + RD_LAT + 2; i++) begin
      if (i == 0)      issue(MEM_READ, 0, 1'b0, 8'h09, 8'h00);
      else if (i == 1) issue(MEM_WRITE, int'(SRC_SAVE), 1'b1, 8'h09, 8'h5A);
      else if (i == 2) issue(MEM_READ, 0, 1'b1, 8'h09, 8'h00);
      tick();
      if (i == 0) a = cyc;
      if (rsp_valid === 1'b1 && n < 8) begin gd[n] = rsp_data; gc[n] = cyc; n++; end
    end
    n_cmp++; if (n != 2) begin n_err++; $display("FAIL b2b_count got %0d exp 2", n); end
    n_cmp++; if (gd[0] !== 8'h99 || gc[0] != a + RD_LAT - 1) begin n_err++; $display("FAIL b2b_old got d=%h c=%0d exp d=99 c=%0d", gd[0], gc[0], a + RD_LAT - 1); end
    n_cmp++; if (gd[1] !== 8'h5A || gc[1] != a + RD_LAT + 1) begin n_err++; $display("FAIL b2b_new got d=%h c=%0d exp d=5a c=%0d", gd[1], gc[1], a + RD_LAT + 1); end
  endtask

  task automatic test_rmw_wrap();
    int low, a, rc;
    logic [7:0] rd;
    issue(MEM_WRITE, int'(SRC_ACC), 1'b0, 8'h07, 8'hFF); tick();
    issue(MEM_INC, 0, 1'b0, 8'h07, 8'h00); tick();
    a = cyc; low = 0; rc = -1; rd = 8'hXX;
    for (int k = 0; k < RD_LAT + 3 && req_ready !== 1'b1; k++) begin
      low++;
      if (rsp_valid === 1'b1) begin rd = rsp_data; rc = cyc; end
      tick();
    end
    n_cmp++; if (low != RD_LAT) begin n_err++; $display("FAIL rmw_ready_low got %0d exp %0d", low, RD_LAT); end
    n_cmp++; if (rd !== 8'h00 || rc != a + RD_LAT - 1) begin n_err++; $display("FAIL rmw_inc got d=%h c=%0d exp d=00 c=%0d", rd, rc, a + RD_LAT - 1); end
    issue(MEM_READ, 0, 1'b0, 8'h07, 8'h00); repeat (RD_LAT) tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h00) begin n_err++; $display("FAIL rmw_readback got v=%b d=%h exp v=1 d=00", rsp_valid, rsp_data); end
    issue(MEM_DEC, 0, 1'b1, 8'h07, 8'h00); repeat (RD_LAT) tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hFF) begin n_err++; $display("FAIL rmw_dec got v=%b d=%h exp v=1 d=ff", rsp_valid, rsp_data); end
    tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rmw_ready_back got %b exp 1", req_ready); end
  endtask

  task automatic test_fault();
    issue(MEM_WRITE, int'(SRC_ACC), 1'b0, 8'hC8, 8'h55); tick();
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL fault_set got %b exp 1", fault); end
    issue(MEM_READ, 0, 1'b0, 8'hC8, 8'h00); repeat (RD_LAT) tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_data !== 8'h00)
      begin n_err++; $display("FAIL fault_rsp got v=%b f=%b d=%h exp v=1 f=1 d=00", rsp_valid, rsp_fault, rsp_data); end
    issue(MEM_READ, 0, 1'b0, 8'h00, 8'h00); repeat (RD_LAT) tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_data !== 8'h00)
      begin n_err++; $display("FAIL fault_cell0 got v=%b f=%b d=%h exp v=1 f=0 d=00", rsp_valid, rsp_fault, rsp_data); end
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL fault_sticky got %b exp 1", fault); end
  endtask

  task automatic test_reset_mid_rmw();
    int n;
    bit seen;
    issue(MEM_WRITE, int'(SRC_ACC), 1'b0, 8'h03, 8'h5A); tick();
    issue(MEM_INC, 0, 1'b0, 8'h03, 8'h00); tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_fault !== 1'b0)
      begin n_err++; $display("FAIL mid_rst_rsp got v=%b d=%h f=%b exp v=0 d=00 f=0", rsp_valid, rsp_data, rsp_fault); end
    n_cmp++; if (fault !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags got fault=%b ready=%b exp 0 0", fault, req_ready); end
    seen = 1'b0;
    repeat (3) begin tick(); if (rsp_valid !== 1'b0) seen = 1'b1; end
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    model_fault = 1'b0; q.delete(); cyc = 0; busy_until = DEPTH;
    reset = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 400) begin
      if (rsp_valid !== 1'b0) seen = 1'b1;
      n++; tick();
    end
    n_cmp++; if (seen) begin n_err++; $display("FAIL mid_rst_no_rsp got rsp_valid seen exp none"); end
    n_cmp++; if (n != DEPTH) begin n_err++; $display("FAIL mid_rst_clear got %0d cycles exp %0d", n, DEPTH); end
    issue(MEM_READ, 0, 1'b0, 8'h03, 8'h00); repeat (RD_LAT) tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_cell got v=%b d=%h exp v=1 d=00", rsp_valid, rsp_data); end
  endtask

  task automatic test_random();
    logic exp_v;
    logic [7:0] a;
    q.delete();
    for (int i = 0; i < 400 + RD_LAT + 2; i++) begin
      n_cmp++; if (req_ready !== (cyc >= busy_until)) begin n_err++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, req_ready, cyc >= busy_until); end
      if (i < 400 && $urandom_range(0, 3) != 0) begin
        a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 15));
        issue(mem_op_t'(3'($urandom_range(0, 4))), int'($urandom_range(0, 7)), 1'($urandom), a, 8'($urandom));
      end
      tick();
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      n_cmp++; if (rsp_valid !== exp_v) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, rsp_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (rsp_data !== q[0].data || rsp_fault !== q[0].flt)
          begin n_err++; $display("FAIL rnd_rsp cyc %0d got d=%h f=%b exp d=%h f=%b", cyc, rsp_data, rsp_fault, q[0].data, q[0].flt); end
        void'(q.pop_front());
      end
      n_cmp++; if (fault !== model_fault) begin n_err++; $display("FAIL rnd_fault cyc %0d got %b exp %b", cyc, fault, model_fault); end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; busy_until = 0; model_fault = 1'b0;
    test_reset();
    test_clear();
    test_write_read();
    test_streaming();
    test_back_to_back();
    test_rmw_wrap();
    test_fault();
    test_reset_mid_rmw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
